// File: rtl/rs_issue_arbiter_pkg.sv
// Shared scheduler types for the reservation-station issue path.
package rs_issue_arbiter_pkg;

   typedef struct packed {
      logic [5:0]  rob_idx;
      logic [5:0]  prd;
      logic        prd_valid;
      logic [11:0] imm;
   } IssueBaseSt;

   typedef struct packed {
      logic [3:0] opcode;
      logic       is_signed;
   } OptionCodeSt;

   // Pointer increment that wraps explicitly, so non-power-of-two counts never reach REQ_NUM.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned num);
      return (idx == num - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module round_robin_picker #(
   parameter int REQ_NUM = 4,
   parameter int IDX_W   = $clog2(REQ_NUM)
) (
   input  logic [REQ_NUM-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [REQ_NUM-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any_valid
);

   logic [2*REQ_NUM-1:0] dbl_req;
   logic                 found;

   assign dbl_req   = {req, req};
   assign any_valid = |req;

   // Lower copy is masked below ptr; the upper copy supplies the wrapped-around candidates.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 0; i < 2 * REQ_NUM; i++) begin
         if (!found && dbl_req[i] && (i >= REQ_NUM || i >= int'(ptr))) begin
            found = 1'b1;
            idx   = IDX_W'(i % REQ_NUM);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < REQ_NUM; gi++) begin : g_onehot
         assign grant[gi] = any_valid && (idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/rs_issue_arbiter.sv
// Round-robin arbiter sharing one FU issue port among REQ_NUM reservation stations,
// with a one-entry registered output stage.
module rs_issue_arbiter
   import rs_issue_arbiter_pkg::*;
#(
   parameter int  REQ_NUM     = 4,
   parameter type OPTION_CODE = OptionCodeSt
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush_i,
   input  logic [REQ_NUM-1:0]             req_valid_i,
   input  IssueBaseSt [REQ_NUM-1:0]       req_base_i,
   input  OPTION_CODE [REQ_NUM-1:0]       req_oc_i,
   output logic [REQ_NUM-1:0]             req_ready_o,
   input  logic                           fu_busy_i,
   output logic                           issue_valid_o,
   input  logic                           issue_ready_i,
   output IssueBaseSt                     issue_base_o,
   output OPTION_CODE                     issue_oc_o,
   output logic [$clog2(REQ_NUM)-1:0]     issue_src_o
);

   localparam int IDX_W = $clog2(REQ_NUM);

   logic [IDX_W-1:0]   rr_reg;
   logic [IDX_W-1:0]   rr_next;
   logic               valid_reg;
   IssueBaseSt         base_reg;
   OPTION_CODE         oc_reg;
   logic [IDX_W-1:0]   src_reg;

   logic [REQ_NUM-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               any_valid;
   logic               reg_free;
   logic               accept;

   round_robin_picker #(
      .REQ_NUM (REQ_NUM),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req       (req_valid_i),
      .ptr       (rr_reg),
      .grant     (grant),
      .idx       (grant_idx),
      .any_valid (any_valid)
   );

   assign reg_free = !valid_reg || issue_ready_i;
   assign accept   = any_valid && reg_free && !fu_busy_i && !flush_i;
   assign rr_next  = IDX_W'(wrap_inc(int'(grant_idx), REQ_NUM));

   // rst_n gates the grant so stations never pop while the output stage is held in reset.
   assign req_ready_o = (accept && rst_n) ? grant : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg <= 1'b0;
         base_reg  <= '0;
         oc_reg    <= '0;
         src_reg   <= '0;
         rr_reg    <= '0;
      end else if (flush_i) begin
         valid_reg <= 1'b0;
         rr_reg    <= '0;
      end else if (accept) begin
         valid_reg <= 1'b1;
         base_reg  <= req_base_i[grant_idx];
         oc_reg    <= req_oc_i[grant_idx];
         src_reg   <= grant_idx;
         rr_reg    <= rr_next;
      end else if (issue_ready_i) begin
         valid_reg <= 1'b0;
      end
   end

   assign issue_valid_o = valid_reg;
   assign issue_base_o  = base_reg;
   assign issue_oc_o    = oc_reg;
   assign issue_src_o   = src_reg;

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Bench: a 4-station and a 3-station arbiter driven in lockstep against a queue-free reference model.
module tb_rs_issue_arbiter;
   import rs_issue_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              flush, busy, iready;
   logic [3:0]        v;
   IssueBaseSt [3:0]  base;
   OptionCodeSt [3:0] oc;

   logic [3:0]  rdy4;
   logic        val4;
   IssueBaseSt  b4;
   OptionCodeSt o4;
   logic [1:0]  s4;

   logic [2:0]  rdy3;
   logic        val3;
   IssueBaseSt  b3;
   OptionCodeSt o3;
   logic [1:0]  s3;

   rs_issue_arbiter #(.REQ_NUM(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .req_valid_i(v), .req_base_i(base), .req_oc_i(oc), .req_ready_o(rdy4),
      .fu_busy_i(busy), .issue_valid_o(val4), .issue_ready_i(iready),
      .issue_base_o(b4), .issue_oc_o(o4), .issue_src_o(s4)
   );

   rs_issue_arbiter #(.REQ_NUM(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .req_valid_i(v[2:0]), .req_base_i(base[2:0]), .req_oc_i(oc[2:0]), .req_ready_o(rdy3),
      .fu_busy_i(busy), .issue_valid_o(val3), .issue_ready_i(iready),
      .issue_base_o(b3), .issue_oc_o(o3), .issue_src_o(s3)
   );

   // Reference model, index 0 = 4 stations, index 1 = 3 stations.
   int          nreq [2] = '{4, 3};
   int          m_rr [2];
   bit          m_v  [2];
   IssueBaseSt  m_base [2];
   OptionCodeSt m_oc [2];
   int          m_src [2];

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic int pick(input logic [3:0] vv, input int rr, input int n);
      for (int k = 0; k < n; k++) begin
         if (vv[(rr + k) % n]) return (rr + k) % n;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rr[k] = 0; m_v[k] = 0; m_base[k] = '0; m_oc[k] = '0; m_src[k] = 0;
      end
   endtask

   task automatic check_out();
      check("valid4", 32'(val4), 32'(m_v[0]));
      if (m_v[0]) begin
         check("base4", 32'(b4), 32'(m_base[0]));
         check("oc4", 32'(o4), 32'(m_oc[0]));
         check("src4", 32'(s4), m_src[0]);
      end
      check("valid3", 32'(val3), 32'(m_v[1]));
      if (m_v[1]) begin
         check("base3", 32'(b3), 32'(m_base[1]));
         check("oc3", 32'(o3), 32'(m_oc[1]));
         check("src3", 32'(s3), m_src[1]);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rdy4"}, 32'(rdy4), 0);
      check({tag, "_rdy3"}, 32'(rdy3), 0);
      check({tag, "_val4"}, 32'(val4), 0);
      check({tag, "_val3"}, 32'(val3), 0);
      check({tag, "_base4"}, 32'(b4), 0);
      check({tag, "_oc4"}, 32'(o4), 0);
      check({tag, "_src4"}, 32'(s4), 0);
      check({tag, "_base3"}, 32'(b3), 0);
      check({tag, "_oc3"}, 32'(o3), 0);
      check({tag, "_src3"}, 32'(s3), 0);
   endtask

   task automatic randomize_payload();
      logic [31:0] tmp;
      for (int i = 0; i < 4; i++) begin
         tmp = $urandom;
         base[i] = tmp[$bits(IssueBaseSt)-1:0];
         tmp = $urandom;
         oc[i] = tmp[$bits(OptionCodeSt)-1:0];
      end
   endtask

   // One clock cycle, entered and left at a falling edge.
   task automatic cycle(input logic [3:0] vv, input logic bz, input logic fl, input logic rd);
      int          g [2];
      bit          acc [2];
      logic [31:0] exp_rdy;
      v = vv; busy = bz; flush = fl; iready = rd;
      randomize_payload();
      #1;
      for (int k = 0; k < 2; k++) begin
         g[k]   = pick(vv, m_rr[k], nreq[k]);
         acc[k] = (g[k] >= 0) && (!m_v[k] || rd) && !bz && !fl;
      end
      exp_rdy = acc[0] ? (32'd1 << g[0]) : 32'd0;
      check("ready4", 32'(rdy4), exp_rdy);
      exp_rdy = acc[1] ? (32'd1 << g[1]) : 32'd0;
      check("ready3", 32'(rdy3), exp_rdy);
      $display("cycle t=%0t v=%b busy=%b flush=%b rdy=%b grant4=%0d acc4=%0d grant3=%0d acc3=%0d",
               $time, vv, bz, fl, rd, g[0], acc[0], g[1], acc[1]);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (fl) begin
            m_v[k] = 0; m_rr[k] = 0;
         end else if (acc[k]) begin
            m_v[k] = 1; m_base[k] = base[g[k]]; m_oc[k] = oc[g[k]]; m_src[k] = g[k];
            m_rr[k] = (g[k] + 1) % nreq[k];
         end else if (rd) begin
            m_v[k] = 0;
         end
      end
      #1;
      check_out();
      @(negedge clk);
   endtask

   initial begin
      v = 4'hf; busy = 1'b0; flush = 1'b0; iready = 1'b1;
      randomize_payload();
      model_reset();
      @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // single requester on station 2
      repeat (3) cycle(4'b0100, 1'b0, 1'b0, 1'b1);
      // flush to bring pointer to 0, then all stations valid
      cycle(4'b0000, 1'b0, 1'b1, 1'b1);
      repeat (5) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      // backpressure with stations 1 and 3 valid
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      repeat (4) cycle(4'b1010, 1'b0, 1'b0, 1'b0);
      cycle(4'b1010, 1'b0, 1'b0, 1'b1);
      // FU busy with empty register
      cycle(4'b0000, 1'b0, 1'b0, 1'b1);
      repeat (2) cycle(4'b0001, 1'b1, 1'b0, 1'b1);
      cycle(4'b0001, 1'b0, 1'b0, 1'b1);
      // flush while full and station 1 valid
      cycle(4'b0010, 1'b0, 1'b0, 1'b0);
      cycle(4'b0010, 1'b0, 1'b1, 1'b0);
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);

      for (int i = 0; i < 300; i++) begin
         cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
      end

      // asynchronous reset mid-stream with the register full
      repeat (4) cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) cycle(4'b1111, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
